// File: rtl/mux4way_arbiter_if.sv
// mux4way_arbiter_if: four valid/ready source channels merged onto one tagged output channel
interface mux4way_arbiter_if #(parameter int WIDTH = 16);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;
  modport slave  (input  in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
  modport master (output in_valid, in_data, out_ready, input  in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/mux4way_arbiter.sv
// mux4way_arbiter: round-robin 4-to-1 merge into a one-entry registered output tagged with its source
module mux4way_arbiter #(parameter int WIDTH = 16) (
  input logic              clk,
  input logic              reset,
  mux4way_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d, rr_q, rr_d, gidx, idx;
  logic [3:0]       vld;
  logic             found, take;
  logic [WIDTH-1:0] src [4];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 2'b00;
      rr_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  always_comb begin
    found = 1'b0;
    gidx  = rr_q;
    idx   = rr_q;
    for (int k = 0; k < 4; k++) begin
      // unknown valid bits must never win a grant
      vld[k] = bus.in_valid[k] === 1'b1;
      src[k] = bus.in_data[k*WIDTH +: WIDTH];
    end
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && vld[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    take         = found && (state_q == EMPTY || bus.out_ready) && !reset;
    bus.in_ready = take ? 4'b0001 << gidx : 4'b0000;
    state_d      = take || (state_q == FULL && !bus.out_ready) ? FULL : EMPTY;
    data_d       = take ? src[gidx] : data_q;
    sel_d        = take ? gidx : sel_q;
    rr_d         = take ? gidx + 2'd1 : rr_q;
  end
  assign bus.out_valid = state_q == FULL;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_mux4way_arbiter.sv
// tb_mux4way_arbiter: directed scenario tasks with hand-computed expectations
module tb_mux4way_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;
  mux4way_arbiter_if #(16) bus();
  mux4way_arbiter #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 4'b0000;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    bus.in_valid = 4'b1111;
    #1;
    total++; if (bus.in_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", bus.in_ready); else pass_cnt++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_data !== 16'h0000) $display("FAIL reset_data got %h want 0000", bus.out_data); else pass_cnt++;
    total++; if (bus.out_sel !== 2'b00) $display("FAIL reset_sel got %b want 00", bus.out_sel); else pass_cnt++;
    reset = 1'b0;
    bus.in_valid = 4'b0100;
    bus.in_data = {16'h0, 16'hBEEF, 16'h0, 16'h0};
    #1;
    total++; if (bus.in_ready !== 4'b0100) $display("FAIL reset_first_ready got %b want 0100", bus.in_ready); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hBEEF) $display("FAIL reset_fill got %b/%h want 1/beef", bus.out_valid, bus.out_data); else pass_cnt++;
    #2;
    reset = 1'b1;
    bus.in_valid = 4'b1111;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL midreset_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_data !== 16'h0000) $display("FAIL midreset_data got %h want 0000", bus.out_data); else pass_cnt++;
    total++; if (bus.out_sel !== 2'b00) $display("FAIL midreset_sel got %b want 00", bus.out_sel); else pass_cnt++;
    total++; if (bus.in_ready !== 4'b0000) $display("FAIL midreset_ready got %b want 0000", bus.in_ready); else pass_cnt++;
    reset = 1'b0;
    #1;
    total++; if (bus.in_ready !== 4'b0001) $display("FAIL postreset_grant got %b want 0001", bus.in_ready); else pass_cnt++;
    bus.in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    bus.in_valid = 4'b0100;
    bus.in_data = {16'h0, 16'h1234, 16'h0, 16'h0};
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 4'b0100) $display("FAIL single_ready got %b want 0100", bus.in_ready); else pass_cnt++;
    tick();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_data !== 16'h1234) $display("FAIL single_data got %h want 1234", bus.out_data); else pass_cnt++;
    total++; if (bus.out_sel !== 2'b10) $display("FAIL single_sel got %b want 10", bus.out_sel); else pass_cnt++;
    bus.in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bus.in_valid = 4'b1111;
    bus.in_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (bus.out_sel !== 2'(i % 4)) $display("FAIL rr_sel[%0d] got %b want %b", i, bus.out_sel, 2'(i % 4)); else pass_cnt++;
      total++; if (bus.out_data !== 16'(i % 4 + 1)) $display("FAIL rr_data[%0d] got %h want %h", i, bus.out_data, 16'(i % 4 + 1)); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    bus.in_valid = 4'b0010;
    tick();
    total++; if (bus.out_sel !== 2'b01) $display("FAIL stall_setup got %b want 01", bus.out_sel); else pass_cnt++;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.in_ready !== 4'b0000) $display("FAIL stall_ready[%0d] got %b want 0000", i, bus.in_ready); else pass_cnt++;
      tick();
      total++; if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 2'b01, 16'h0002}) $display("FAIL stall_hold[%0d] got %b/%b/%h want 1/01/0002", i, bus.out_valid, bus.out_sel, bus.out_data); else pass_cnt++;
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 4'b0100) $display("FAIL stall_release_ready got %b want 0100", bus.in_ready); else pass_cnt++;
    tick();
    total++; if (bus.out_sel !== 2'b10 || bus.out_data !== 16'h0003) $display("FAIL stall_release got %b/%h want 10/0003", bus.out_sel, bus.out_data); else pass_cnt++;
  endtask

  task automatic test_wrap();
    bus.in_valid = 4'b1000;
    tick();
    total++; if (bus.out_sel !== 2'b11 || bus.out_data !== 16'h0004) $display("FAIL wrap_d got %b/%h want 11/0004", bus.out_sel, bus.out_data); else pass_cnt++;
    bus.in_valid = 4'b0001;
    tick();
    total++; if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 2'b00, 16'h0001}) $display("FAIL wrap_a got %b/%b/%h want 1/00/0001", bus.out_valid, bus.out_sel, bus.out_data); else pass_cnt++;
  endtask

  task automatic test_drain();
    bus.in_valid = 4'b0000;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_data !== 16'h0001 || bus.out_sel !== 2'b00) $display("FAIL drain_hold got %h/%b want 0001/00", bus.out_data, bus.out_sel); else pass_cnt++;
    tick();
    tick();
    bus.in_valid = 4'b1111;
    #1;
    total++; if (bus.in_ready !== 4'b0010) $display("FAIL drain_rr got %b want 0010", bus.in_ready); else pass_cnt++;
    bus.in_valid = 4'b01x0;
    #1;
    total++; if (bus.in_ready !== 4'b0100) $display("FAIL xvalid_grant got %b want 0100", bus.in_ready); else pass_cnt++;
    bus.in_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap();
    test_drain();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
